// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional zero register,
// write bypass and a one-entry-per-cycle clear sequencer.
module reg_file_mp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wr_adr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_adr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_zero;
  logic wr_ok;

  assign wr_zero = (ZERO_REG != 0) && (wr_adr == '0);
  assign wr_ok   = we && (state == IDLE) && !wr_zero;

  // Clear sequencer: walks idx over every entry, busy mirrors CLEAR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          idx <= idx + ADDR_W'(1);
          if (idx == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Storage: sweep zeroes win over writes, which are blocked while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_adr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              rzero;
    logic              rbyp;

    assign ra    = rd_adr[k*ADDR_W +: ADDR_W];
    assign rzero = (ZERO_REG != 0) && (ra == '0);
    assign rbyp  = (BYPASS != 0) && wr_ok && (wr_adr == ra);

    assign rd_data[k*DATA_W +: DATA_W] =
      rzero ? '0 :
      rbyp  ? wr_data :
              mem[ra];
  end

endmodule
